// File: rtl/tp_ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tp_ntt_pkg
// Purpose  : Shared sizing functions and MSB-first lane slicing for TP-NTT.
// Revision : 1.0 - initial release
// ============================================================================
package tp_ntt_pkg;

  // Words per bank per half.
  function automatic int tp_depth(input int n, input int tp);
    return n / tp;
  endfunction

  function automatic int tp_ld(input int n, input int tp);
    return $clog2(n / tp);
  endfunction

  // One extra address bit selects the ping-pong half.
  function automatic int tp_aw(input int n, input int tp);
    return $clog2(n / tp) + 1;
  endfunction

  function automatic int tp_rw(input int tp);
    return $clog2(tp);
  endfunction

  // LSB position of lane i inside a TP-lane bus; lane 0 sits in the MSBs.
  function automatic int lane_lsb(input int tp, input int i, input int w);
    return (tp - 1 - i) * w;
  endfunction

endpackage : tp_ntt_pkg
`default_nettype wire

// File: rtl/tp_bank_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : tp_bank_buffer_if
// Purpose  : Write/read bus between the TP-NTT address generator and buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface tp_bank_buffer_if
  import tp_ntt_pkg::*;
#(
  parameter int N    = 128,
  parameter int TP   = 8,
  parameter int LOGQ = 32
);
  localparam int AW = tp_aw(N, TP);
  localparam int RW = tp_rw(TP);

  logic                 wr_en;
  logic [TP*AW-1:0]     write_addr;
  logic [TP*LOGQ-1:0]   wr_data;
  logic                 rd_en;
  logic [TP*AW-1:0]     read_addr;
  logic [RW-1:0]        rd_rot;
  logic [TP*LOGQ-1:0]   rd_data;
  logic                 rd_valid;
  logic [1:0]           half_full;

  modport master (
    output wr_en, write_addr, wr_data, rd_en, read_addr, rd_rot,
    input  rd_data, rd_valid, half_full
  );

  modport slave (
    input  wr_en, write_addr, wr_data, rd_en, read_addr, rd_rot,
    output rd_data, rd_valid, half_full
  );

endinterface : tp_bank_buffer_if
`default_nettype wire

// File: rtl/tp_bank_ram.sv
`default_nettype none
// ============================================================================
// Module   : tp_bank_ram
// Purpose  : One coefficient bank, 2*DEPTH words, 1 write + 1 registered read.
//            TP_BUF_FWD_EN selects write-first on an address collision.
// Revision : 1.0 - initial release
// ============================================================================
module tp_bank_ram #(
  parameter int DEPTH = 16,
  parameter int LOGQ  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [$clog2(2*DEPTH)-1:0]    wr_addr,
  input  logic [LOGQ-1:0]               wr_data,
  input  logic                          rd_en,
  input  logic [$clog2(2*DEPTH)-1:0]    rd_addr,
  output logic [LOGQ-1:0]               rd_data
);
  localparam int ENTRIES = 2 * DEPTH;

  logic [LOGQ-1:0] mem [ENTRIES];
  logic [LOGQ-1:0] rd_data_d;
  logic [LOGQ-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
`ifdef TP_BUF_FWD_EN
      if (wr_en && (wr_addr == rd_addr)) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = mem[rd_addr];
      end
`else
      // Array read sees pre-edge contents, giving read-first on collision.
      rd_data_d = mem[rd_addr];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule : tp_bank_ram
`default_nettype wire

// File: rtl/tp_bank_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tp_bank_buffer
// Purpose  : TP-bank ping-pong buffer with read de-rotation and half tracking.
//            Optional macro TP_BUF_FWD_EN: write-first read/write collisions.
// Revision : 1.0 - initial release
// ============================================================================
module tp_bank_buffer
  import tp_ntt_pkg::*;
#(
  parameter int N    = 128,
  parameter int TP   = 8,
  parameter int LOGQ = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  tp_bank_buffer_if.slave   bus
);
  localparam int DEPTH = tp_depth(N, TP);
  localparam int LD    = tp_ld(N, TP);
  localparam int AW    = tp_aw(N, TP);
  localparam int RW    = tp_rw(TP);
  localparam int CW    = LD + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  logic [LOGQ-1:0]    bank_rd [TP];
  logic [TP*LOGQ-1:0] rot_word;

  logic               rd_en_s1_d, rd_en_s1_q;
  logic [RW-1:0]      rot_s1_d,   rot_s1_q;
  logic [TP*LOGQ-1:0] rd_data_d,  rd_data_q;
  logic               rd_valid_d, rd_valid_q;

  logic [1:0]         half_full_d, half_full_q;
  logic [CW-1:0]      wr_cnt_d [2];
  logic [CW-1:0]      wr_cnt_q [2];
  logic [CW-1:0]      rd_cnt_d [2];
  logic [CW-1:0]      rd_cnt_q [2];

  logic               wr_half;
  logic               rd_half;

  generate
    for (genvar j = 0; j < TP; j++) begin : g_bank
      tp_bank_ram #(
        .DEPTH (DEPTH),
        .LOGQ  (LOGQ)
      ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.write_addr[lane_lsb(TP, j, AW) +: AW]),
        .wr_data (bus.wr_data[lane_lsb(TP, j, LOGQ) +: LOGQ]),
        .rd_en   (bus.rd_en),
        .rd_addr (bus.read_addr[lane_lsb(TP, j, AW) +: AW]),
        .rd_data (bank_rd[j])
      );
    end

    // Output lane i takes bank (i + rot) mod TP; RW-bit wrap does the modulo.
    for (genvar i = 0; i < TP; i++) begin : g_lane
      logic [RW-1:0] src;
      assign src = RW'(i) + rot_s1_q;
      assign rot_word[lane_lsb(TP, i, LOGQ) +: LOGQ] = bank_rd[src];
    end
  endgenerate

  always_comb begin
    rd_en_s1_d = bus.rd_en;
    rot_s1_d   = bus.rd_en ? bus.rd_rot : rot_s1_q;
    rd_valid_d = rd_en_s1_q;
    rd_data_d  = rd_en_s1_q ? rot_word : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_s1_q <= 1'b0;
      rot_s1_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_en_s1_q <= rd_en_s1_d;
      rot_s1_q   <= rot_s1_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Half selection follows the bank-0 address MSB only.
  assign wr_half = bus.write_addr[TP*AW-1];
  assign rd_half = bus.read_addr[TP*AW-1];

  always_comb begin
    half_full_d = half_full_q;
    for (int h = 0; h < 2; h++) begin
      wr_cnt_d[h] = wr_cnt_q[h];
      rd_cnt_d[h] = rd_cnt_q[h];
      if (bus.wr_en && (wr_half == 1'(h)) && !half_full_q[h]) begin
        if (wr_cnt_q[h] == CNT_LAST) begin
          half_full_d[h] = 1'b1;
          wr_cnt_d[h]    = '0;
        end else begin
          wr_cnt_d[h] = wr_cnt_q[h] + CW'(1);
        end
      end
      if (bus.rd_en && (rd_half == 1'(h)) && half_full_q[h]) begin
        if (rd_cnt_q[h] == CNT_LAST) begin
          half_full_d[h] = 1'b0;
          rd_cnt_d[h]    = '0;
        end else begin
          rd_cnt_d[h] = rd_cnt_q[h] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_full_q <= '0;
      for (int h = 0; h < 2; h++) begin
        wr_cnt_q[h] <= '0;
        rd_cnt_q[h] <= '0;
      end
    end else begin
      half_full_q <= half_full_d;
      for (int h = 0; h < 2; h++) begin
        wr_cnt_q[h] <= wr_cnt_d[h];
        rd_cnt_q[h] <= rd_cnt_d[h];
      end
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.half_full = half_full_q;

endmodule : tp_bank_buffer
`default_nettype wire

// File: tb/tb_tp_bank_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tp_bank_buffer
// Purpose  : Directed scoreboard bench for tp_bank_buffer (N=128, TP=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tp_bank_buffer;
  localparam int N     = 128;
  localparam int TP    = 8;
  localparam int LOGQ  = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 5;
  localparam int RW    = 3;
  localparam int W     = TP * LOGQ;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tp_bank_buffer_if #(.N(N), .TP(TP), .LOGQ(LOGQ)) bus();

  tp_bank_buffer #(.N(N), .TP(TP), .LOGQ(LOGQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t            sb[$];
  int              checks = 0;
  int              errors = 0;
  int              cyc    = 0;
  int              wa [TP];
  int              ra [TP];
  logic [LOGQ-1:0] wd [TP];
  logic [LOGQ-1:0] mdl [TP][2*DEPTH];
  logic [W-1:0]    vec;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rd_valid_spurious", W'(bus.rd_valid), W'(0));
      end else begin
        e = sb.pop_front();
        chk("rd_data", bus.rd_data, e.data);
        chk("rd_latency", W'(cyc), W'(e.due));
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      chk("rd_valid_missing", W'(bus.rd_valid), W'(1));
      void'(sb.pop_front());
    end
  endtask

  task automatic op(input bit we, input bit re, input int rot);
    exp_t e;
    int   b;
    bus.wr_en  = we;
    bus.rd_en  = re;
    bus.rd_rot = RW'(rot);
    for (int i = 0; i < TP; i++) begin
      bus.write_addr[(TP-1-i)*AW +: AW]  = AW'(wa[i]);
      bus.read_addr[(TP-1-i)*AW +: AW]   = AW'(ra[i]);
      bus.wr_data[(TP-1-i)*LOGQ +: LOGQ] = wd[i];
    end
    if (re) begin
      e.data = '0;
      e.due  = cyc + 2;
      for (int i = 0; i < TP; i++) begin
        b = (i + rot) % TP;
        e.data[(TP-1-i)*LOGQ +: LOGQ] = mdl[b][ra[b]];
`ifdef TP_BUF_FWD_EN
        if (we && (wa[b] == ra[b])) e.data[(TP-1-i)*LOGQ +: LOGQ] = wd[b];
`endif
      end
      sb.push_back(e);
    end
    if (we) begin
      for (int i = 0; i < TP; i++) mdl[i][wa[i]] = wd[i];
    end
    tick();
  endtask

  task automatic set_addr(input int a_w, input int a_r);
    for (int i = 0; i < TP; i++) begin
      wa[i] = a_w;
      ra[i] = a_r;
    end
  endtask

  initial begin
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.rd_rot     = '0;
    bus.write_addr = '0;
    bus.read_addr  = '0;
    bus.wr_data    = '0;
    for (int i = 0; i < TP; i++) begin
      wa[i] = 0; ra[i] = 0; wd[i] = '0;
    end

    // Power-on reset values
    #12;
    chk("reset_rd_data", bus.rd_data, W'(0));
    chk("reset_rd_valid", W'(bus.rd_valid), W'(0));
    chk("reset_half_full", W'(bus.half_full), W'(0));
    #10 rst_n = 1'b1;
    tick();

    // Fill half 0
    for (int k = 0; k < DEPTH; k++) begin
      set_addr(k, 0);
      for (int i = 0; i < TP; i++) wd[i] = LOGQ'(16*k + i);
      op(1'b1, 1'b0, 0);
      if (k == DEPTH-2) chk("fill_15", W'(bus.half_full), W'(2'b00));
      if (k == DEPTH-1) chk("fill_16", W'(bus.half_full), W'(2'b01));
    end

    // Plain read at address 3
    set_addr(0, 3);
    op(1'b0, 1'b1, 0);
    op(1'b0, 1'b0, 0);
    op(1'b0, 1'b0, 0);
    for (int i = 0; i < TP; i++) vec[(TP-1-i)*LOGQ +: LOGQ] = LOGQ'(48 + i);
    chk("read_addr3", bus.rd_data, vec);
    op(1'b0, 1'b0, 0);
    chk("hold_data", bus.rd_data, vec);
    chk("hold_valid_low", W'(bus.rd_valid), W'(0));

    // Rotated read: bank j at (j-3) mod 8
    for (int j = 0; j < TP; j++) ra[j] = (j + 5) % TP;
    op(1'b0, 1'b1, 3);
    op(1'b0, 1'b0, 0);
    op(1'b0, 1'b0, 0);
    for (int i = 0; i < TP; i++) vec[(TP-1-i)*LOGQ +: LOGQ] = LOGQ'(16*i + (i + 3) % TP);
    chk("rotate3", bus.rd_data, vec);
    chk("half_full_after_2_reads", W'(bus.half_full), W'(2'b01));

    // Drain: 14 more counted reads finish the 16
    for (int k = 0; k < 14; k++) begin
      set_addr(0, k);
      op(1'b0, 1'b1, k % TP);
      if (k == 12) chk("drain_15", W'(bus.half_full), W'(2'b01));
      if (k == 13) chk("drain_16", W'(bus.half_full), W'(2'b00));
    end
    set_addr(0, 7);
    op(1'b0, 1'b1, 2);
    chk("drain_17th", W'(bus.half_full), W'(2'b00));
    for (int k = 0; k < 3; k++) op(1'b0, 1'b0, 0);

    // Refill half 0 with fresh data
    for (int k = 0; k < DEPTH; k++) begin
      set_addr(k, 0);
      for (int i = 0; i < TP; i++) wd[i] = LOGQ'(32'h1000 + 16*k + i);
      op(1'b1, 1'b0, 0);
    end
    chk("refill", W'(bus.half_full), W'(2'b01));

    // Ping-pong: write half 1 while draining half 0 from t=8
    for (int t = 0; t < 24; t++) begin
      set_addr(16 + (t % 16), (t >= 8) ? t - 8 : 0);
      for (int i = 0; i < TP; i++) wd[i] = LOGQ'(32'h2000 + 16*t + i);
      op(t < 16, t >= 8, t % TP);
      if (t == 14) chk("pp_t14", W'(bus.half_full), W'(2'b01));
      if (t == 15) chk("pp_t15", W'(bus.half_full), W'(2'b11));
      if (t == 22) chk("pp_t22", W'(bus.half_full), W'(2'b11));
      if (t == 23) chk("pp_t23", W'(bus.half_full), W'(2'b10));
    end
    for (int k = 0; k < 3; k++) op(1'b0, 1'b0, 0);

    // Same-bank same-address collision at address 20
    set_addr(20, 20);
    for (int i = 0; i < TP; i++) wd[i] = 32'h0000_AAAA;
    op(1'b1, 1'b1, 0);
    op(1'b0, 1'b0, 0);
    op(1'b0, 1'b0, 0);
`ifdef TP_BUF_FWD_EN
    for (int i = 0; i < TP; i++) vec[(TP-1-i)*LOGQ +: LOGQ] = 32'h0000_AAAA;
`else
    for (int i = 0; i < TP; i++) vec[(TP-1-i)*LOGQ +: LOGQ] = LOGQ'(32'h2040 + i);
`endif
    chk("collision", bus.rd_data, vec);
    op(1'b0, 1'b1, 0);
    op(1'b0, 1'b0, 0);
    op(1'b0, 1'b0, 0);
    for (int i = 0; i < TP; i++) vec[(TP-1-i)*LOGQ +: LOGQ] = 32'h0000_AAAA;
    chk("after_collision", bus.rd_data, vec);

    // Mid-stream reset with reads in flight
    set_addr(0, 5);
    op(1'b0, 1'b1, 1);
    set_addr(0, 6);
    op(1'b0, 1'b1, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_rd_data", bus.rd_data, W'(0));
    chk("midreset_rd_valid", W'(bus.rd_valid), W'(0));
    chk("midreset_half_full", W'(bus.half_full), W'(0));
    sb.delete();
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    #10 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_reset_valid", W'(bus.rd_valid), W'(0));
    end

    chk("scoreboard_empty", W'(sb.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_tp_bank_buffer
`default_nettype wire

// File: doc/tp_bank_buffer.md
Name: tp_bank_buffer

Overview:
- TP-bank ping-pong coefficient buffer sitting directly downstream of the TP-NTT large address generator.
- Writes one TP-lane word per cycle at per-lane write addresses and reads one TP-lane word per cycle at per-lane read addresses.
- Undoes the generator's lane rotation on the read side, so lane i of the output always carries logical coefficient lane i.
- Tracks fill/drain of each half so the butterfly stage can start on a complete frame.

Parameters:
- N, 128, polynomial length.
- TP, 8, lanes/banks; power of two, 2 ≤ TP ≤ N.
- LOGQ, 32, coefficient width.
- Derived: DEPTH=N/TP, LD=clog2(DEPTH), AW=LD+1, RW=clog2(TP).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe.
- write_addr  in  TP*AW  per-bank write address; bank i field = bits[(TP-i)*AW-1 -: AW] (bank 0 in MSBs); bit LD selects half.
- wr_data  in  TP*LOGQ  lane i = bits[(TP-i)*LOGQ-1 -: LOGQ].
- rd_en  in  1  read strobe.
- read_addr  in  TP*AW  per-bank read address, same packing.
- rd_rot  in  RW  lane rotation applied by the producer for this read.
- rd_data  out  TP*LOGQ  de-rotated read word, same packing.
- rd_valid  out  1  rd_data valid.
- half_full  out  2  half h holds a complete frame.

Behaviour:
- Storage: TP banks, each 2*DEPTH x LOGQ; no reset of contents.
- Write: when wr_en=1, bank i stores wr_data lane i at its write_addr field on the clock edge.
- Read stage 1: when rd_en=1, each bank j registers mem_j[read_addr field j]. rd_rot and rd_en are delayed alongside.
- Read stage 2 (output register):
  - rd_data lane i = stage-1 bank ((i+rot_d) mod TP).
  - rd_valid = rd_en delayed 2 cycles. Latency is fixed at 2 cycles.
  - rd_data holds its last value when the corresponding rd_en was 0.
- Same-bank, same-address read and write in one cycle: read-first; returns the old contents unless TP_BUF_FWD_EN is defined.
- Half tracking:
  - wr_cnt[h] and rd_cnt[h], each LD+1 bits.
  - The half is taken from the bank-0 address MSB.
  - A write to half h with half_full[h]=0 increments wr_cnt[h]. Reaching DEPTH sets half_full[h] and clears wr_cnt[h].
  - A read from half h with half_full[h]=1 increments rd_cnt[h]. Reaching DEPTH clears half_full[h] and rd_cnt[h].
  - Writes into a full half still update memory but are not counted. Reads from a non-full half still return data but are not counted.
  - Simultaneous completion events on different halves are independent.
- Reset (async assert, sync deassert assumed upstream):
  - rd_data=0, rd_valid=0, half_full=2'b00, all counters 0, delay registers 0.
  - Mid-operation reset drops any in-flight reads (no rd_valid afterwards).

Optional Feature:
- TP_BUF_FWD_EN defined: on a same-bank/same-address read+write collision, stage 1 captures wr_data for that lane (write-first). The comparison is per bank.
- TP_BUF_FWD_EN undefined: read-first as above; no comparator logic.

Decomposition:
- Package tp_ntt_pkg holds:
  - functions for DEPTH/LD/AW/RW derivation;
  - the lane-field slice helper (MSB-first packing) shared with the address generator.
- One sub-module, tp_bank_ram: single bank, 1 write port + 1 registered read port, depth 2*DEPTH. It contains the forwarding mux under TP_BUF_FWD_EN.
- The top instantiates TP of these, plus the rotator and the counters.

Test Plan (N=128, TP=8, DEPTH=16, AW=5):
- Reset: assert rst_n=0 mid-stream with rd_en=1 -> rd_data=0, rd_valid=0, half_full=00 asynchronously; no rd_valid after release.
- Fill half 0: 16 writes, all lane addresses=k (k=0..15), lane i data=16*k+i -> half_full=01 on the edge after the 16th write. Then read all lanes at address 3 with rd_rot=0 -> 2 cycles later lane i = 48+i, rd_valid=1.
- Rotation: after the fill above, read with rd_rot=3 where bank j address=(j-3 mod 8) -> rd_data lane i = 16*i+i re-ordered per the generator's pattern, checked against a model.
- Drain: 16 counted reads from half 0 -> half_full[0] clears after the 16th. A 17th read still returns data with half_full unchanged.
- Ping-pong: write half 1 (addresses 16..31) while reading half 0 -> half_full goes 01→11→10 with correct counts.
- Collision: write 0xAAAA and read the same bank/address in the same cycle -> old value returned; 0xAAAA returned with TP_BUF_FWD_EN.
